// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: reset vector, IF state encoding and
// instruction field positions used by fetch and the control unit.
package mips_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int FUNCT_MSB = 5;
   localparam int FUNCT_LSB = 0;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2,
      S_DROP  = 2'd3
   } if_state_e;

   // Branch displacement in bytes: sign-extended word offset.
   function automatic logic [31:0] br_disp(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory fetch port: req/addr out, single-cycle ready/rdata back.
interface if_stage_if #(
   parameter int AW = 32
);
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ready;
   logic [31:0]   imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );
endinterface

// File: rtl/if_stage_npc_calc.sv
// Combinational PC arithmetic: sequential increments and redirect target.
module npc_calc
   import mips_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic [31:0] skid_pc_i,
   input  logic [31:0] br_base_i,
   input  logic [15:0] br_imm16_i,
   input  logic [25:0] j_target26_i,
   input  logic        jump_i,
   output logic [31:0] pc_plus4_o,
   output logic [31:0] skid_plus4_o,
   output logic [31:0] target_o
);

   logic [31:0] br_tgt;
   logic [31:0] j_tgt;

   assign pc_plus4_o   = pc_i + 32'd4;
   assign skid_plus4_o = skid_pc_i + 32'd4;
   assign br_tgt       = br_base_i + br_disp(br_imm16_i);
   assign j_tgt        = {br_base_i[31:28], j_target26_i, 2'b00};

   // jal takes priority when both redirects fire together.
   assign target_o = jump_i ? j_tgt : br_tgt;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, imem handshake, IF/ID register,
// one-entry skid for decode stalls and redirect/flush handling.
module if_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          IMEM_AW  = 32
) (
   input  logic        clk,
   input  logic        rst,
   if_stage_if.master  imem,
   input  logic        id_stall,
   input  logic        br_taken,
   input  logic        jump,
   input  logic [31:0] br_base,
   input  logic [15:0] br_imm16,
   input  logic [25:0] j_target26,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [5:0]  op,
   output logic [5:0]  funct,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4
);

   if_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] drop_addr_q, drop_addr_d;
   logic [31:0] skid_q, skid_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;

   logic        redirect;
   logic        out_free;
   logic        req;
   logic [31:0] pc_inc;
   logic [31:0] skid_inc;
   logic [31:0] target;

   npc_calc u_npc (
      .pc_i         (pc_q),
      .skid_pc_i    (skid_pc_q),
      .br_base_i    (br_base),
      .br_imm16_i   (br_imm16),
      .j_target26_i (j_target26),
      .jump_i       (jump),
      .pc_plus4_o   (pc_inc),
      .skid_plus4_o (skid_inc),
      .target_o     (target)
   );

   assign redirect = jump | br_taken;
   assign out_free = ~valid_q | ~id_stall;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      drop_addr_d = drop_addr_q;
      skid_d      = skid_q;
      skid_pc_d   = skid_pc_q;
      instr_d     = instr_q;
      pc_out_d    = pc_out_q;
      pc4_d       = pc4_q;
      valid_d     = valid_q;
      req         = 1'b0;

      unique case (state_q)
         S_BOOT: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            req = 1'b1;
            if (redirect) begin
               // An unanswered request must still be drained.
               if (!imem.imem_ready) begin
                  drop_addr_d = pc_q;
                  state_d     = S_DROP;
               end
            end else if (imem.imem_ready) begin
               pc_d = pc_inc;
               if (out_free) begin
                  instr_d  = imem.imem_rdata;
                  pc_out_d = pc_q;
                  pc4_d    = pc_inc;
                  valid_d  = 1'b1;
               end else begin
                  skid_d    = imem.imem_rdata;
                  skid_pc_d = pc_q;
                  state_d   = S_HOLD;
               end
            end else if (valid_q && !id_stall) begin
               valid_d = 1'b0;
            end
         end
         S_HOLD: begin
            if (redirect) begin
               state_d = S_FETCH;
            end else if (!id_stall) begin
               instr_d  = skid_q;
               pc_out_d = skid_pc_q;
               pc4_d    = skid_inc;
               valid_d  = 1'b1;
               state_d  = S_FETCH;
            end
         end
         S_DROP: begin
            req = 1'b1;
            if (imem.imem_ready) begin
               state_d = S_FETCH;
            end
         end
         default: begin
            state_d = S_BOOT;
         end
      endcase

      // Redirect overrides every other PC/output update.
      if (redirect) begin
         pc_d    = target;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_BOOT;
         pc_q        <= RESET_PC;
         drop_addr_q <= '0;
         skid_q      <= '0;
         skid_pc_q   <= '0;
         instr_q     <= '0;
         pc_out_q    <= '0;
         pc4_q       <= '0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_addr_q <= drop_addr_d;
         skid_q      <= skid_d;
         skid_pc_q   <= skid_pc_d;
         instr_q     <= instr_d;
         pc_out_q    <= pc_out_d;
         pc4_q       <= pc4_d;
         valid_q     <= valid_d;
      end
   end

   assign imem.imem_req  = req;
   assign imem.imem_addr = IMEM_AW'((state_q == S_DROP) ? drop_addr_q : pc_q);

   assign instr_valid = valid_q;
   assign instr       = instr_q;
   assign op          = instr_q[OP_MSB:OP_LSB];
   assign funct       = instr_q[FUNCT_MSB:FUNCT_LSB];
   assign pc_out      = pc_out_q;
   assign pc_plus4    = pc4_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: boot, stall/skid, redirects, reset, PC wrap.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_stall;
   logic        br_taken;
   logic        jump;
   logic [31:0] br_base;
   logic [15:0] br_imm16;
   logic [25:0] j_target26;
   logic        instr_valid;
   logic [31:0] instr;
   logic [5:0]  op;
   logic [5:0]  funct;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;

   logic        auto_rsp;
   logic        man_ready;
   logic [31:0] man_rdata;

   int vectors = 0;
   int errs    = 0;

   if_stage_if #(.AW(32)) bus ();

   // Auto mode: memory answers every request at once with its address.
   assign bus.imem_ready = auto_rsp ? bus.imem_req  : man_ready;
   assign bus.imem_rdata = auto_rsp ? bus.imem_addr : man_rdata;

   if_stage dut (
      .clk         (clk),
      .rst         (rst),
      .imem        (bus.master),
      .id_stall    (id_stall),
      .br_taken    (br_taken),
      .jump        (jump),
      .br_base     (br_base),
      .br_imm16    (br_imm16),
      .j_target26  (j_target26),
      .instr_valid (instr_valid),
      .instr       (instr),
      .op          (op),
      .funct       (funct),
      .pc_out      (pc_out),
      .pc_plus4    (pc_plus4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst        = 1'b1;
      id_stall   = 1'b0;
      br_taken   = 1'b0;
      jump       = 1'b0;
      br_base    = '0;
      br_imm16   = '0;
      j_target26 = '0;
      auto_rsp   = 1'b1;
      man_ready  = 1'b0;
      man_rdata  = '0;

      #2;
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_pcout", pc_out, 32'd0);
      chk("rst_pc4", pc_plus4, 32'd0);
      chk("rst_req", 32'(bus.imem_req), 32'd0);
      chk("rst_addr", bus.imem_addr, 32'h3000);
      #10 rst = 1'b0;

      step();
      chk("boot_valid", 32'(instr_valid), 32'd0);
      chk("boot_req", 32'(bus.imem_req), 32'd1);
      chk("boot_addr", bus.imem_addr, 32'h3000);
      step();
      chk("f0_valid", 32'(instr_valid), 32'd1);
      chk("f0_pcout", pc_out, 32'h3000);
      chk("f0_instr", instr, 32'h3000);
      chk("f0_pc4", pc_plus4, 32'h3004);
      step();
      chk("f1_pcout", pc_out, 32'h3004);
      step();
      chk("f2_pcout", pc_out, 32'h3008);
      chk("f2_funct", 32'(funct), 32'h08);

      id_stall = 1'b1;
      step();
      chk("st1_pcout", pc_out, 32'h3008);
      chk("st1_valid", 32'(instr_valid), 32'd1);
      chk("st1_req", 32'(bus.imem_req), 32'd0);
      step();
      step();
      chk("st3_pcout", pc_out, 32'h3008);
      id_stall = 1'b0;
      step();
      chk("sk_pcout", pc_out, 32'h300C);
      chk("sk_instr", instr, 32'h300C);
      chk("sk_pc4", pc_plus4, 32'h3010);
      chk("sk_addr", bus.imem_addr, 32'h3010);
      step();
      chk("sk2_pcout", pc_out, 32'h3010);
      chk("sk2_valid", 32'(instr_valid), 32'd1);

      auto_rsp = 1'b0;
      br_taken = 1'b1;
      br_base  = 32'h3010;
      br_imm16 = 16'hFFFC;
      step();
      br_taken = 1'b0;
      chk("br_valid", 32'(instr_valid), 32'd0);
      chk("br_dreq", 32'(bus.imem_req), 32'd1);
      chk("br_daddr", bus.imem_addr, 32'h3014);
      step();
      chk("br_daddr2", bus.imem_addr, 32'h3014);
      man_ready = 1'b1;
      man_rdata = 32'hDEAD_BEEF;
      step();
      man_ready = 1'b0;
      chk("br_valid2", 32'(instr_valid), 32'd0);
      chk("br_tgt", bus.imem_addr, 32'h3000);
      man_ready = 1'b1;
      man_rdata = 32'h2408_0025;
      step();
      man_ready = 1'b0;
      chk("t_pcout", pc_out, 32'h3000);
      chk("t_op", 32'(op), 32'h09);
      chk("t_funct", 32'(funct), 32'h25);
      chk("t_valid", 32'(instr_valid), 32'd1);

      jump       = 1'b1;
      br_base    = 32'h3010;
      j_target26 = 26'h0000C10;
      step();
      jump = 1'b0;
      chk("j_valid", 32'(instr_valid), 32'd0);
      chk("j_daddr", bus.imem_addr, 32'h3004);
      man_ready = 1'b1;
      man_rdata = 32'h1111_1111;
      step();
      man_ready = 1'b0;
      chk("j_tgt", bus.imem_addr, 32'h3040);

      man_ready = 1'b1;
      man_rdata = 32'h0000_0020;
      step();
      chk("rr_pre", pc_out, 32'h3040);
      id_stall  = 1'b1;
      man_rdata = 32'hBAD0_BAD0;
      br_taken  = 1'b1;
      br_base   = 32'h3044;
      br_imm16  = 16'h0010;
      step();
      br_taken  = 1'b0;
      id_stall  = 1'b0;
      chk("rr_valid", 32'(instr_valid), 32'd0);
      chk("rr_req", 32'(bus.imem_req), 32'd1);
      chk("rr_addr", bus.imem_addr, 32'h3084);

      man_rdata = 32'hAAAA_0001;
      step();
      chk("h_pcout", pc_out, 32'h3084);
      id_stall  = 1'b1;
      man_rdata = 32'hBBBB_0002;
      step();
      man_ready = 1'b0;
      chk("h_req", 32'(bus.imem_req), 32'd0);
      chk("h_instr", instr, 32'hAAAA_0001);
      #2 rst = 1'b1;
      #1;
      chk("ar_valid", 32'(instr_valid), 32'd0);
      chk("ar_instr", instr, 32'd0);
      chk("ar_pcout", pc_out, 32'd0);
      chk("ar_addr", bus.imem_addr, 32'h3000);
      chk("ar_req", 32'(bus.imem_req), 32'd0);
      #3 rst = 1'b0;
      id_stall = 1'b0;
      step();
      chk("rb_addr", bus.imem_addr, 32'h3000);
      chk("rb_req", 32'(bus.imem_req), 32'd1);

      jump       = 1'b1;
      br_base    = 32'hF000_0000;
      j_target26 = 26'h3FF_FFFF;
      step();
      jump      = 1'b0;
      man_ready = 1'b1;
      man_rdata = 32'h0;
      step();
      chk("w_addr", bus.imem_addr, 32'hFFFF_FFFC);
      man_rdata = 32'h1234_5678;
      step();
      man_ready = 1'b0;
      chk("w_pcout", pc_out, 32'hFFFF_FFFC);
      chk("w_pc4", pc_plus4, 32'h0);
      chk("w_addr0", bus.imem_addr, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
